// File: rtl/mdriver_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue sequencer for the AXI-Lite master wrapper's mdriver port.
// Optional watchdog on the wait-for-fin phase is enabled with `define SEQ_TIMEOUT_EN.
module mdriver_cmd_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              drv_exec,
    output logic              drv_we,
    output logic [ADDR_W-1:0] drv_address,
    output logic [DATA_W-1:0] drv_data,
    input  logic [DATA_W-1:0] drv_rdata,
    input  logic              drv_fin
);
    // state | meaning
    // IDLE  | waiting for a queued command; pops the head into drv_* when one exists
    // ISSUE | drv_exec pulse to the wrapper
    // WAIT  | command outstanding, waiting for drv_fin
    // RESP  | response presented, held until rsp_ready
    // HALT  | watchdog fired; only rst leaves this state
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HALT} state_t;

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic              fifo_we   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    // No bypass: a full FIFO refuses a push even while the same edge pops.
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cmd_addr;
            fifo_data[wr_ptr] <= cmd_data;
            fifo_we[wr_ptr]   <= cmd_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            drv_exec    <= 1'b0;
            drv_we      <= 1'b0;
            drv_address <= '0;
            drv_data    <= '0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_data    <= '0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            drv_exec <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        drv_we      <= fifo_we[rd_ptr];
                        drv_address <= fifo_addr[rd_ptr];
                        drv_data    <= fifo_data[rd_ptr];
                        drv_exec    <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // drv_we is still the issued direction here, so it selects the capture.
                    if (drv_fin) begin
                        rsp_we    <= drv_we;
                        rsp_data  <= drv_we ? '0 : drv_rdata;
                        rsp_valid <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= S_RESP;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        rsp_we    <= drv_we;
                        rsp_data  <= '0;
                        rsp_err_q <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdriver_cmd_sequencer.sv
// Directed bench for mdriver_cmd_sequencer; inputs driven and outputs sampled on the falling edge.
// The watchdog scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_mdriver_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_we;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        drv_exec;
    logic        drv_we;
    logic [31:0] drv_address;
    logic [31:0] drv_data;
    logic [31:0] drv_rdata = '0;
    logic        drv_fin = 1'b0;

    int checks = 0;
    int errors = 0;

    mdriver_cmd_sequencer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .drv_exec(drv_exec), .drv_we(drv_we), .drv_address(drv_address),
        .drv_data(drv_data), .drv_rdata(drv_rdata), .drv_fin(drv_fin)
    );

    always #5 clk = ~clk;

    // Pushes one command; returns at the falling edge right after the accepting edge.
    task automatic push_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout addr=%h cmd_ready=%b required 1", a, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for exec, checks the issued command, answers after dly cycles and accepts the response.
    task automatic do_cmd(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [31:0] rd, input int dly);
        int n;
        logic extra;
        n = 0;
        extra = 1'b0;
        while (drv_exec !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (drv_exec !== 1'b1) begin
            errors++;
            $display("FAIL exec_timeout addr=%h drv_exec=%b required 1", a, drv_exec);
            return;
        end
        checks++;
        if (drv_address !== a || drv_we !== we || (we && drv_data !== d)) begin
            errors++;
            $display("FAIL exec_cmd got addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                     drv_address, drv_we, drv_data, a, we, d);
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (drv_exec !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL exec_single_pulse addr=%h extra exec seen, required one pulse", a);
        end
        drv_fin = 1'b1; drv_rdata = rd;
        checks++;
        if (drv_address !== a || drv_we !== we || (we && drv_data !== d) || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_at_fin got addr=%h we=%b data=%h rsp_valid=%b required addr=%h we=%b data=%h rsp_valid=0",
                     drv_address, drv_we, drv_data, rsp_valid, a, we, d);
        end
        @(negedge clk);
        drv_fin = 1'b0; drv_rdata = 32'hFFFF_FFFF;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_we !== we || rsp_data !== (we ? 32'h0 : rd) || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL response got valid=%b we=%b data=%h err=%b required valid=1 we=%b data=%h err=0",
                     rsp_valid, rsp_we, rsp_data, rsp_err, we, (we ? 32'h0 : rd));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, drv_exec, drv_we, drv_address, drv_data}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b rv=%b rwe=%b rd=%h err=%b ex=%b we=%b a=%h d=%h required rdy=1 others 0",
                     cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, drv_exec, drv_we, drv_address, drv_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        push_cmd(1'b0, 32'h10, 32'h0);
        checks++;
        if (drv_exec !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_early drv_exec=%b required 0 in push cycle", drv_exec);
        end
        @(negedge clk);
        checks++;
        if (drv_exec !== 1'b1) begin
            errors++;
            $display("FAIL read_latency drv_exec=%b required 1 one cycle after push", drv_exec);
        end
        do_cmd(32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 3);
    endtask

    task automatic test_write();
        push_cmd(1'b1, 32'h20, 32'h1234_5678);
        do_cmd(32'h20, 1'b1, 32'h1234_5678, 32'hCAFE_0001, 2);
    endtask

    task automatic test_full();
        int acc;
        logic take;
        acc = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cmd_valid = (acc < 6);
            cmd_we = 1'b0;
            cmd_addr = 32'h100 + 32'(acc * 4);
            take = cmd_valid && cmd_ready;
            @(negedge clk);
            if (take) acc++;
        end
        checks++;
        if (acc != 5 || cmd_ready !== 1'b0 || drv_address !== 32'h100) begin
            errors++;
            $display("FAIL full_accept got accepted=%0d cmd_ready=%b addr=%h required 5, 0, 00000100",
                     acc, cmd_ready, drv_address);
        end
        drv_fin = 1'b1; drv_rdata = 32'hA000_0000;
        @(negedge clk);
        drv_fin = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA000_0000 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_rsp0 got valid=%b data=%h cmd_ready=%b required 1 a0000000 0",
                     rsp_valid, rsp_data, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_no_bypass cmd_ready=%b required 0 in pop cycle", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || drv_exec !== 1'b1 || drv_address !== 32'h104) begin
            errors++;
            $display("FAIL full_after_pop got cmd_ready=%b exec=%b addr=%h required 1 1 00000104",
                     cmd_ready, drv_exec, drv_address);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        drv_fin = 1'b1; drv_rdata = 32'hA000_0001;
        @(negedge clk);
        drv_fin = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hA000_0001) begin
            errors++;
            $display("FAIL full_rsp1 got valid=%b data=%h required 1 a0000001", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 2; i < 6; i++)
            do_cmd(32'h100 + 32'(i * 4), 1'b0, 32'h0, 32'hA000_0000 + 32'(i), 1);
        checks++;
        if (cmd_ready !== 1'b1 || drv_exec !== 1'b0) begin
            errors++;
            $display("FAIL full_drained got cmd_ready=%b exec=%b required 1 0", cmd_ready, drv_exec);
        end
    endtask

    task automatic test_back_to_back();
        logic bad;
        bad = 1'b0;
        push_cmd(1'b0, 32'h200, 32'h0);
        push_cmd(1'b1, 32'h204, 32'h0000_0055);
        checks++;
        if (drv_exec !== 1'b1 || drv_address !== 32'h200) begin
            errors++;
            $display("FAIL bp_exec got exec=%b addr=%h required 1 00000200", drv_exec, drv_address);
        end
        @(negedge clk);
        drv_fin = 1'b1; drv_rdata = 32'h0000_0077;
        @(negedge clk);
        drv_fin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h77 || rsp_we !== 1'b0 || drv_exec !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold rsp changed or exec seen; now valid=%b data=%h required 1 00000077, no exec",
                     rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || drv_exec !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got valid=%b exec=%b required 0 0", rsp_valid, drv_exec);
        end
        @(negedge clk);
        checks++;
        if (drv_exec !== 1'b1 || drv_address !== 32'h204) begin
            errors++;
            $display("FAIL bp_next_exec got exec=%b addr=%h required 1 00000204", drv_exec, drv_address);
        end
        do_cmd(32'h204, 1'b1, 32'h0000_0055, 32'h0, 1);
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        push_cmd(1'b0, 32'h400, 32'h0);
        @(negedge clk);
        checks++;
        if (drv_exec !== 1'b1) begin
            errors++;
            $display("FAIL to_exec drv_exec=%b required 1", drv_exec);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_early rsp_valid=%b required 0 after 7 wait cycles", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL to_rsp got valid=%b err=%b data=%h required 1 1 00000000", rsp_valid, rsp_err, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        push_cmd(1'b0, 32'h404, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (drv_exec !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL to_halt exec or rsp_valid seen in HALT, or cmd_ready low; required none");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, drv_exec, drv_we, drv_address, drv_data}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL to_reset got rdy=%b rv=%b err=%b a=%h required reset values",
                     cmd_ready, rsp_valid, rsp_err, drv_address);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_wait();
        logic bad;
        bad = 1'b0;
        push_cmd(1'b0, 32'h500, 32'h0);
        push_cmd(1'b1, 32'h504, 32'h1);
        push_cmd(1'b0, 32'h508, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_we, rsp_data, rsp_err, drv_exec, drv_we, drv_address, drv_data}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_values got rdy=%b rv=%b ex=%b we=%b a=%h d=%h required rdy=1 others 0",
                     cmd_ready, rsp_valid, drv_exec, drv_we, drv_address, drv_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (drv_exec !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_mid_flushed exec or response after reset, required none");
        end
        push_cmd(1'b0, 32'h600, 32'h0);
        do_cmd(32'h600, 1'b0, 32'h0, 32'h0BAD_F00D, 1);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_full();
        test_back_to_back();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
